telem_ft_packer: RTL and testbench

TELEM_FT_PACKER -- requirements
Module: telem_ft_packer

---
 rtl/telem_ft_packer.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_telem_ft_packer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/telem_ft_packer.sv
// telem_ft_packer
//
// Buffers 88-bit telemetry packets in a small FIFO, tags each one with an
// 8-bit sequence number, and serializes every buffered packet as a frame of
// 16-bit words toward an FT-style transmit buffer that has a full/ready
// handshake.
//
// Frame layout (one FIFO entry {seq, data[87:0]}):
//   word 0 : {HDR_MARK, seq}
//   word 1 : data[87:72]
//   word 2 : data[71:56]
//   word 3 : data[55:40]
//   word 4 : data[39:24]
//   word 5 : data[23:8]
//   word 6 : {data[7:0], 8'h00}
//   word 7 : CRC-16-CCITT over words 0..6 (only with TELEM_FT_PACKER_CRC_EN)
//
// Optional feature macro: TELEM_FT_PACKER_CRC_EN
//   Undefined (default) : 7-word frames, no CRC hardware.
//   Defined             : 8-word frames, CRC-16-CCITT (poly 1021, init FFFF,
//                         MSB first, no reflection, no final XOR).
//
// Parameters:
//   FIFO_DEPTH : packet slots buffered (power of two, 2..16)
//   HDR_MARK   : upper byte of every header word
//
// Ports:
//   clk             : single clock
//   rst             : synchronous active-high reset
//   packet_data     : 88-bit packet from the unpacker
//   packet_valid    : one-cycle strobe qualifying packet_data
//   enable          : gates incoming strobes only
//   reset_counters  : synchronous clear of dropped_packets / sent_frames
//   ui_din          : word offered to the transmit buffer
//   ui_din_be       : byte enables (2'b11 while a word is offered)
//   ui_din_valid    : word offered
//   ui_din_full     : transmit buffer full; transfer when valid & ~full
//   dropped_packets : enabled strobes lost to a full FIFO (saturating)
//   sent_frames     : completed frames (wrapping)
//   busy            : FIFO non-empty or a frame in progress

module telem_ft_packer #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  HDR_MARK   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [87:0] packet_data,
  input  logic        packet_valid,
  input  logic        enable,
  input  logic        reset_counters,
  output logic [15:0] ui_din,
  output logic [1:0]  ui_din_be,
  output logic        ui_din_valid,
  input  logic        ui_din_full,
  output logic [31:0] dropped_packets,
  output logic [31:0] sent_frames,
  output logic        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef TELEM_FT_PACKER_CRC_EN
  typedef enum logic [1:0] {IDLE, HDR, DATA, CRC} state_t;
`else
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`endif

  state_t             state;
  logic [2:0]         word_idx;
  logic [7:0]         seq;

  logic [95:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   rd_ptr_next;
  logic [CNT_W-1:0]   fifo_count;

  logic               fifo_full;
  logic               fifo_empty;
  logic               accept;
  logic               push;
  logic               pop;
  logic               xfer;
  logic               more_queued;
  logic [95:0]        head;
  logic [95:0]        next_head;

`ifdef TELEM_FT_PACKER_CRC_EN
  logic [15:0]        crc;
  logic [15:0]        crc_upd;
`endif

  // Picks one 16-bit word of a frame out of a stored {seq, data} entry.
  function automatic logic [15:0] frame_word(input logic [95:0] e,
                                             input logic [2:0]  idx);
    logic [15:0] w;
    case (idx)
      3'd0:    w = {HDR_MARK, e[95:88]};
      3'd1:    w = e[87:72];
      3'd2:    w = e[71:56];
      3'd3:    w = e[55:40];
      3'd4:    w = e[39:24];
      3'd5:    w = e[23:8];
      3'd6:    w = {e[7:0], 8'h00};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

`ifdef TELEM_FT_PACKER_CRC_EN
  // One whole 16-bit word folded into the CRC, MSB first.
  function automatic logic [15:0] crc16_word(input logic [15:0] c_in,
                                             input logic [15:0] w);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ w[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  assign crc_upd = crc16_word(crc, ui_din);
`endif

  // Full is judged on the registered count, so a pop in the same cycle
  // never rescues a strobe that arrives while the FIFO is full.
  assign fifo_full   = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty  = (fifo_count == '0);
  assign accept      = packet_valid & enable;
  assign push        = accept & ~fifo_full;
  assign xfer        = ui_din_valid & ~ui_din_full;
  assign rd_ptr_next = rd_ptr + 1'b1;
  assign head        = fifo_mem[rd_ptr];
  assign next_head   = fifo_mem[rd_ptr_next];
  assign more_queued = (fifo_count > CNT_W'(1));
  assign busy        = ~fifo_empty | (state != IDLE);

  // The head entry stays in the FIFO for the whole frame and is released
  // only when the final word of its frame is accepted.
`ifdef TELEM_FT_PACKER_CRC_EN
  assign pop = xfer & (state == CRC);
`else
  assign pop = xfer & (state == DATA) & (word_idx == 3'd6);
`endif

  // Storage array; pointers guard validity so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {seq, packet_data};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr_next;
      fifo_count <= fifo_count + {{(CNT_W-1){1'b0}}, push}
                               - {{(CNT_W-1){1'b0}}, pop};
    end
  end

  // Sequence number advances on every enabled strobe, buffered or dropped.
  always_ff @(posedge clk) begin
    if (rst)         seq <= 8'h00;
    else if (accept) seq <= seq + 8'h01;
  end

  // Statistics; reset_counters wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || reset_counters) begin
      dropped_packets <= 32'h0;
      sent_frames     <= 32'h0;
    end else begin
      if (accept && fifo_full && dropped_packets != 32'hFFFF_FFFF)
        dropped_packets <= dropped_packets + 32'h1;
      if (pop)
        sent_frames <= sent_frames + 32'h1;
    end
  end

  // Frame serializer. Outputs are registered and only change on a transfer
  // (or when starting from IDLE), so a word is held steady under full.
  // When a frame ends and another entry is already queued, the next header
  // is loaded directly so frames run back to back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      word_idx     <= 3'd0;
      ui_din       <= 16'h0000;
      ui_din_be    <= 2'b00;
      ui_din_valid <= 1'b0;
`ifdef TELEM_FT_PACKER_CRC_EN
      crc          <= 16'hFFFF;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            ui_din       <= frame_word(head, 3'd0);
            ui_din_be    <= 2'b11;
            ui_din_valid <= 1'b1;
            word_idx     <= 3'd0;
            state        <= HDR;
`ifdef TELEM_FT_PACKER_CRC_EN
            crc          <= 16'hFFFF;
`endif
          end
        end

        HDR: begin
          if (xfer) begin
            ui_din   <= frame_word(head, 3'd1);
            word_idx <= 3'd1;
            state    <= DATA;
`ifdef TELEM_FT_PACKER_CRC_EN
            crc      <= crc_upd;
`endif
          end
        end

        DATA: begin
          if (xfer) begin
`ifdef TELEM_FT_PACKER_CRC_EN
            crc <= crc_upd;
`endif
            if (word_idx == 3'd6) begin
`ifdef TELEM_FT_PACKER_CRC_EN
              ui_din <= crc_upd;
              state  <= CRC;
`else
              if (more_queued) begin
                ui_din   <= frame_word(next_head, 3'd0);
                word_idx <= 3'd0;
                state    <= HDR;
              end else begin
                ui_din       <= 16'h0000;
                ui_din_be    <= 2'b00;
                ui_din_valid <= 1'b0;
                word_idx     <= 3'd0;
                state        <= IDLE;
              end
`endif
            end else begin
              ui_din   <= frame_word(head, word_idx + 3'd1);
              word_idx <= word_idx + 3'd1;
            end
          end
        end

`ifdef TELEM_FT_PACKER_CRC_EN
        CRC: begin
          if (xfer) begin
            if (more_queued) begin
              ui_din   <= frame_word(next_head, 3'd0);
              word_idx <= 3'd0;
              crc      <= 16'hFFFF;
              state    <= HDR;
            end else begin
              ui_din       <= 16'h0000;
              ui_din_be    <= 2'b00;
              ui_din_valid <= 1'b0;
              word_idx     <= 3'd0;
              state        <= IDLE;
            end
          end
        end
`endif

        default: begin
          state        <= IDLE;
          ui_din_valid <= 1'b0;
          ui_din_be    <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_telem_ft_packer.sv
// Testbench for telem_ft_packer.
// Directed stimulus pushes the expected word stream of each buffered packet
// into a queue; an independent monitor on the falling clock edge pops and
// compares every word the DUT transfers, and also checks that a word offered
// under ui_din_full stays put with valid held high.

module tb_telem_ft_packer;

`ifdef TELEM_FT_PACKER_CRC_EN
  localparam int FW = 8;
`else
  localparam int FW = 7;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [87:0] packet_data = '0;
  logic        packet_valid = 1'b0;
  logic        enable = 1'b1;
  logic        reset_counters = 1'b0;
  logic        ui_din_full = 1'b0;
  logic [15:0] ui_din;
  logic [1:0]  ui_din_be;
  logic        ui_din_valid;
  logic [31:0] dropped_packets;
  logic [31:0] sent_frames;
  logic        busy;

  logic [15:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_seq = 8'h00;
  int          exp_sent = 0;
  int          exp_dropped = 0;

  bit          holding = 1'b0;
  logic [15:0] held_word = 16'h0000;

  telem_ft_packer #(.FIFO_DEPTH(4), .HDR_MARK(8'hA5)) dut (
    .clk(clk),
    .rst(rst),
    .packet_data(packet_data),
    .packet_valid(packet_valid),
    .enable(enable),
    .reset_counters(reset_counters),
    .ui_din(ui_din),
    .ui_din_be(ui_din_be),
    .ui_din_valid(ui_din_valid),
    .ui_din_full(ui_din_full),
    .dropped_packets(dropped_packets),
    .sent_frames(sent_frames),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [15:0] ref_crc(input logic [15:0] c_in,
                                          input logic [15:0] w);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ w[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic push_frame(input logic [7:0] s, input logic [87:0] d);
    logic [15:0] w[7];
    logic [15:0] c;
    w[0] = {8'hA5, s};
    w[1] = d[87:72];
    w[2] = d[71:56];
    w[3] = d[55:40];
    w[4] = d[39:24];
    w[5] = d[23:8];
    w[6] = {d[7:0], 8'h00};
    c = 16'hFFFF;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(w[i]);
      c = ref_crc(c, w[i]);
    end
`ifdef TELEM_FT_PACKER_CRC_EN
    exp_q.push_back(c);
`endif
    exp_sent++;
  endtask

  // One-cycle strobe; returns one time step after the sampling edge.
  task automatic apply_stimulus(input logic [87:0] d, input bit buffered);
    packet_data  = d;
    packet_valid = 1'b1;
    if (enable) begin
      if (buffered) push_frame(exp_seq, d);
      else          exp_dropped++;
      exp_seq = exp_seq + 8'h01;
    end
    @(posedge clk);
    #1;
    packet_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("idle_timeout", {31'h0, busy}, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_seq     = 8'h00;
    exp_sent    = 0;
    exp_dropped = 0;
  endtask

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        holding = 1'b0;
      end else begin
        if (holding) begin
          check_output("hold_valid", {31'h0, ui_din_valid}, 32'h1);
          check_output("hold_word", {16'h0, ui_din}, {16'h0, held_word});
        end
        if (ui_din_valid) begin
          check_output("byte_enable", {30'h0, ui_din_be}, 32'h3);
          if (ui_din_full) begin
            holding   = 1'b1;
            held_word = ui_din;
          end else begin
            holding = 1'b0;
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("[TB] FAIL unexpected_word: got %h, required none", ui_din);
            end else begin
              check_output("frame_word", {16'h0, ui_din}, {16'h0, exp_q.pop_front()});
            end
          end
        end else begin
          holding = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [87:0] d;
    logic [87:0] ref_pkt;
    ref_pkt = 88'h0102030405060708090A0B;

    // Reset with a strobe held high: it must be ignored.
    rst = 1'b1;
    packet_valid = 1'b1;
    packet_data  = 88'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    packet_valid = 1'b0;
    check_output("rst_valid", {31'h0, ui_din_valid}, 32'h0);
    check_output("rst_be", {30'h0, ui_din_be}, 32'h0);
    check_output("rst_din", {16'h0, ui_din}, 32'h0);
    check_output("rst_dropped", dropped_packets, 32'h0);
    check_output("rst_sent", sent_frames, 32'h0);
    check_output("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("strobe_in_rst_ignored", {31'h0, busy}, 32'h0);

    // Single packet: header two edges after the strobe edge.
    apply_stimulus(ref_pkt, 1'b1);
    check_output("valid_after_1st_edge", {31'h0, ui_din_valid}, 32'h0);
    @(posedge clk);
    #1;
    check_output("valid_at_2nd_edge", {31'h0, ui_din_valid}, 32'h1);
    check_output("first_header", {16'h0, ui_din}, 32'h0000A500);
    wait_idle(40);
    check_output("sent_after_one", sent_frames, 32'd1);

    // Backpressure on the third word.
    apply_stimulus(ref_pkt, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_output("third_word", {16'h0, ui_din}, 32'h00000304);
    ui_din_full = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_output("third_word_held", {16'h0, ui_din}, 32'h00000304);
    ui_din_full = 1'b0;
    wait_idle(40);
    check_output("sent_after_bp", sent_frames, 32'd2);

    // Overflow: 6 strobes into a 4-deep FIFO while the sink is full.
    do_reset();
    ui_din_full = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = {11{8'(8'h10 + i)}};
      apply_stimulus(d, i < 4);
    end
    check_output("dropped_two", dropped_packets, 32'd2);
    ui_din_full = 1'b0;
    wait_idle(100);
    check_output("sent_four", sent_frames, 32'd4);
    check_output("dropped_model", dropped_packets, 32'(exp_dropped));

    // reset_counters on the same cycle as the last word transfer; the
    // header of this packet carries seq 06.
    apply_stimulus(88'hCAFE0000000000000000F0, 1'b1);
    repeat (FW) @(posedge clk);
    #1;
    reset_counters = 1'b1;
    @(posedge clk);
    #1;
    reset_counters = 1'b0;
    exp_sent    = 0;
    exp_dropped = 0;
    check_output("rc_sent_zero", sent_frames, 32'h0);
    check_output("rc_dropped_zero", dropped_packets, 32'h0);
    wait_idle(40);

    // Disabled strobe is neither buffered nor counted.
    enable = 1'b0;
    apply_stimulus(88'h123, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check_output("disabled_busy", {31'h0, busy}, 32'h0);
    enable = 1'b1;

    // 300 packets, no backpressure; sequence wraps. Packet 5 sees enable
    // drop mid-frame, which must not disturb it.
    for (int i = 0; i < 300; i++) begin
      d = {11{8'(i)}} ^ 88'h00FF00FF00FF00FF00FF00;
      apply_stimulus(d, 1'b1);
      if (i == 5) begin
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b1;
      end
      wait_idle(40);
    end
    check_output("sent_300", sent_frames, 32'd300);
    check_output("sent_model", sent_frames, 32'(exp_sent));
    check_output("dropped_none", dropped_packets, 32'h0);

    // Reset mid-frame with two entries queued.
    apply_stimulus(ref_pkt, 1'b1);
    apply_stimulus(88'h77, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_output("fourth_word", {16'h0, ui_din}, 32'h00000506);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("abort_valid", {31'h0, ui_din_valid}, 32'h0);
    check_output("abort_busy", {31'h0, busy}, 32'h0);
    check_output("abort_sent", sent_frames, 32'h0);
    check_output("abort_dropped", dropped_packets, 32'h0);
    rst = 1'b0;
    exp_q.delete();
    exp_seq  = 8'h00;
    exp_sent = 0;
    apply_stimulus(ref_pkt, 1'b1);
    @(posedge clk);
    #1;
    check_output("post_abort_header", {16'h0, ui_din}, 32'h0000A500);
    wait_idle(40);
    check_output("post_abort_sent", sent_frames, 32'd1);

    check_output("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
